// File: rtl/i2c_slave_mb_if.sv
// i2c_slave_mb_if: pad and application-bus signals of the i2c_slave_mb target.
//   Pad side : scl, sda_i (from pads), sda_o / sda_oe (open-drain driver)
//   App side : rw, addr[AW-1:0], wen, wdata[7:0], rdata[7:0], rdata_used, busy
// Modports: slave (the i2c_slave_mb block), master (the environment driving pads/rdata).
interface i2c_slave_mb_if #(
    parameter int unsigned AW = 8
);
    logic          scl;
    logic          sda_i;
    logic          sda_o;
    logic          sda_oe;
    logic          rw;
    logic [AW-1:0] addr;
    logic          wen;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic          rdata_used;
    logic          busy;

    modport slave (
        input  scl, sda_i, rdata,
        output sda_o, sda_oe, rw, addr, wen, wdata, rdata_used, busy
    );

    modport master (
        output scl, sda_i, rdata,
        input  sda_o, sda_oe, rw, addr, wen, wdata, rdata_used, busy
    );
endinterface

// File: rtl/i2c_slave_mb.sv
// i2c_slave_mb: I2C target with a 1- or 2-byte auto-incrementing sub-address pointer,
// 8-bit read path, repeated-START support and a FILTER_LEN-sample glitch filter.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : i2c_slave_mb_if.slave (scl/sda pads, register-file style app bus)
module i2c_slave_mb #(
    parameter logic [6:0]  SLAVE_ADDR    = 7'h70,
    parameter int unsigned SUBADDR_BYTES = 1,
    parameter int unsigned FILTER_LEN    = 3
) (
    input logic           clk,
    input logic           rst_n,
    i2c_slave_mb_if.slave bus
);
    localparam int unsigned AW       = 8 * SUBADDR_BYTES;
    localparam logic        LAST_SUB = (SUBADDR_BYTES == 2);

    typedef enum logic [3:0] {
        StIdle, StDevAddr, StDevAck, StSubAddr, StSubAck,
        StWrData, StWrAck, StRdData, StRdAck
    } state_e;

    // Synchroniser + glitch filter
    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-1:0] scl_hist, sda_hist;
    logic                  scl_f, sda_f;
    logic                  scl_rise, scl_fall, sda_rise, sda_fall;
    logic                  start_det, stop_det;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
            sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
            if (scl_rise) scl_f <= 1'b1;
            else if (scl_fall) scl_f <= 1'b0;
            if (sda_rise) sda_f <= 1'b1;
            else if (sda_fall) sda_f <= 1'b0;
        end
    end

    always_comb begin
        scl_rise  = !scl_f && (&scl_hist);
        scl_fall  = scl_f && !(|scl_hist);
        sda_rise  = !sda_f && (&sda_hist);
        sda_fall  = sda_f && !(|sda_hist);
        // SDA moving together with an SCL fall (e.g. filters settling after reset) is
        // not a bus condition.
        start_det = sda_fall && scl_f && !scl_fall;
        stop_det  = sda_rise && scl_f && !scl_fall;
    end

    // Protocol FSM and registered outputs
    state_e        state_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [AW-1:0] staging_q;
    logic          sub_idx_q;
    logic          sda_oe_q, rw_q, wen_q, rdata_used_q, busy_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            staging_q    <= '0;
            sub_idx_q    <= 1'b0;
            sda_oe_q     <= 1'b0;
            rw_q         <= 1'b1;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            rdata_used_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wen_q        <= 1'b0;
            rdata_used_q <= 1'b0;
            if (stop_det) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (start_det) begin
                state_q   <= StDevAddr;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                if (scl_rise && (state_q inside {StDevAddr, StSubAddr, StWrData, StRdData})) begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (state_q != StRdData) shift_q <= {shift_q[6:0], sda_f};
                end
                unique case (state_q)
                    StIdle: begin
                    end
                    StDevAddr: begin
                        if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= '0;
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                rw_q     <= shift_q[0];
                                state_q  <= StDevAck;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StDevAck: begin
                        if (scl_fall) begin
                            if (!rw_q) begin
                                sda_oe_q  <= 1'b0;
                                sub_idx_q <= 1'b0;
                                state_q   <= StSubAddr;
                            end else begin
                                // rdata is combinational from the pre-increment addr
                                rdata_used_q <= 1'b1;
                                shift_q      <= bus.rdata;
                                sda_oe_q     <= ~bus.rdata[7];
                                addr_q       <= addr_q + AW'(1);
                                state_q      <= StRdData;
                            end
                        end
                    end
                    StSubAddr: begin
                        if (scl_fall && bit_cnt_q == 4'd8) begin
                            staging_q <= AW'({staging_q, shift_q});
                            sda_oe_q  <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= StSubAck;
                        end
                    end
                    StSubAck: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            if (sub_idx_q == LAST_SUB) begin
                                addr_q  <= staging_q;
                                state_q <= StWrData;
                            end else begin
                                sub_idx_q <= ~sub_idx_q;
                                state_q   <= StSubAddr;
                            end
                        end
                    end
                    StWrData: begin
                        if (scl_fall && bit_cnt_q == 4'd8) begin
                            wen_q     <= 1'b1;
                            wdata_q   <= shift_q;
                            sda_oe_q  <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= StWrAck;
                        end
                    end
                    StWrAck: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            addr_q   <= addr_q + AW'(1);
                            state_q  <= StWrData;
                        end
                    end
                    StRdData: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= StRdAck;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                            end
                        end
                    end
                    StRdAck: begin
                        if (scl_rise && sda_f) begin
                            state_q <= StIdle;      // master NACK ends the read
                        end else if (scl_fall) begin
                            rdata_used_q <= 1'b1;
                            shift_q      <= bus.rdata;
                            sda_oe_q     <= ~bus.rdata[7];
                            addr_q       <= addr_q + AW'(1);
                            state_q      <= StRdData;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.sda_o      = 1'b0;
    assign bus.sda_oe     = sda_oe_q;
    assign bus.rw         = rw_q;
    assign bus.addr       = addr_q;
    assign bus.wen        = wen_q;
    assign bus.wdata      = wdata_q;
    assign bus.rdata_used = rdata_used_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave_mb.sv
// tb_i2c_slave_mb: scoreboard bench for i2c_slave_mb. DUT0 uses a 2-byte pointer,
// DUT1 a 1-byte pointer; one bit-banged master is routed to whichever is selected.
module tb_i2c_slave_mb;
    localparam int Q = 10;   // quarter SCL period in clk cycles

    logic clk = 1'b0;
    logic rst_n;
    logic scl_m, sda_m, sel, sda_line;

    always #5 clk = ~clk;

    i2c_slave_mb_if #(.AW(16)) bus0 ();
    i2c_slave_mb_if #(.AW(8))  bus1 ();

    i2c_slave_mb #(.SUBADDR_BYTES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    i2c_slave_mb #(.SUBADDR_BYTES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.scl   = sel ? 1'b1 : scl_m;
    assign bus1.scl   = sel ? scl_m : 1'b1;
    assign bus0.sda_i = sel ? 1'b1 : (sda_m & ~bus0.sda_oe);
    assign bus1.sda_i = sel ? (sda_m & ~bus1.sda_oe) : 1'b1;
    assign sda_line   = sel ? (sda_m & ~bus1.sda_oe) : (sda_m & ~bus0.sda_oe);
    assign bus0.rdata = bus0.addr[15:8] ^ bus0.addr[7:0];
    assign bus1.rdata = bus1.addr ^ 8'hFF;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Scoreboard queues: {addr, wdata} per wen, post-increment addr per rdata_used
    logic [23:0] wq0[$];
    logic [15:0] wq1[$];
    logic [7:0]  rq1[$];
    logic [23:0] e0;
    logic [15:0] e1;
    logic [7:0]  r1;
    int oe1_cnt = 0, wen1_cnt = 0, ru1_cnt = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus0.wen === 1'b1) begin
            check("wen0_excl", 32'(bus0.rdata_used), 32'd0);
            if (wq0.size() == 0) check("wen0_extra", 32'd1, 32'd0);
            else begin
                e0 = wq0.pop_front();
                check("wen0", 32'({bus0.addr, bus0.wdata}), 32'(e0));
            end
        end
        if (rst_n === 1'b1 && bus0.rdata_used === 1'b1) check("ru0_extra", 32'd1, 32'd0);
    end

    always @(negedge clk) begin
        if (bus1.sda_oe === 1'b1) oe1_cnt++;
        if (rst_n === 1'b1 && bus1.wen === 1'b1) begin
            wen1_cnt++;
            check("wen1_excl", 32'(bus1.rdata_used), 32'd0);
            if (wq1.size() == 0) check("wen1_extra", 32'd1, 32'd0);
            else begin
                e1 = wq1.pop_front();
                check("wen1", 32'({bus1.addr, bus1.wdata}), 32'(e1));
            end
        end
        if (rst_n === 1'b1 && bus1.rdata_used === 1'b1) begin
            ru1_cnt++;
            if (rq1.size() == 0) check("ru1_extra", 32'd1, 32'd0);
            else begin
                r1 = rq1.pop_front();
                check("ru1_addr", 32'(bus1.addr), 32'(r1));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        if (glitch) begin
            scl_m = 1'b0; wait_clk(2);     // 2-clk low pulse, shorter than the filter
            scl_m = 1'b1; wait_clk(Q - 2);
        end else begin
            wait_clk(Q);
        end
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_line; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // exp_line: 0 = target must ACK, 1 = no ACK expected
    task automatic send_byte(input string name, input logic [7:0] data, input logic exp_line,
                             input logic glitch);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(data[i], glitch);
        read_bit(a);
        check(name, 32'(a), 32'(exp_line));
    endtask

    task automatic recv_byte(input string name, input logic [7:0] exp, input logic ack_line);
        logic [7:0] got;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            got[i] = b;
        end
        check(name, 32'(got), 32'(exp));
        write_bit(ack_line, 1'b0);
    endtask

    initial begin
        int oe_snap, wen_snap, ru_snap;
        logic a;
        scl_m = 1'b1; sda_m = 1'b1; sel = 1'b0; rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(2);
        check("rst_oe0",   32'(bus0.sda_oe), 32'd0);
        check("rst_rw0",   32'(bus0.rw),     32'd1);
        check("rst_addr0", 32'(bus0.addr),   32'd0);
        check("rst_busy0", 32'(bus0.busy),   32'd0);
        check("rst_rw1",   32'(bus1.rw),     32'd1);
        check("rst_addr1", 32'(bus1.addr),   32'd0);
        check("sda_o",     32'(bus0.sda_o),  32'd0);

        // 2-byte pointer write of two data bytes
        wq0.push_back({16'h1234, 8'hA5});
        wq0.push_back({16'h1235, 8'h5A});
        i2c_start();
        send_byte("t1_dev", 8'hE0, 1'b0, 1'b0);
        send_byte("t1_sub_hi", 8'h12, 1'b0, 1'b0);
        send_byte("t1_sub_lo", 8'h34, 1'b0, 1'b0);
        send_byte("t1_d0", 8'hA5, 1'b0, 1'b0);
        send_byte("t1_d1", 8'h5A, 1'b0, 1'b0);
        check("t1_busy", 32'(bus0.busy), 32'd1);
        check("t1_rw",   32'(bus0.rw),   32'd0);
        i2c_stop();
        check("t1_busy_stop", 32'(bus0.busy), 32'd0);
        check("t1_addr", 32'(bus0.addr), 32'h1236);
        check("t1_wq_empty", 32'(wq0.size()), 32'd0);

        // Same write without and then with SCL glitches: identical wen sequence
        for (int g = 0; g < 2; g++) begin
            wq0.push_back({16'h0100, 8'h3C});
            wq0.push_back({16'h0101, 8'hC3});
            i2c_start();
            send_byte("t5_dev", 8'hE0, 1'b0, 1'b0);
            send_byte("t5_sub_hi", 8'h01, 1'b0, 1'b0);
            send_byte("t5_sub_lo", 8'h00, 1'b0, 1'b0);
            send_byte("t5_d0", 8'h3C, 1'b0, g[0]);
            send_byte("t5_d1", 8'hC3, 1'b0, g[0]);
            i2c_stop();
            check("t5_addr", 32'(bus0.addr), 32'h0102);
            check("t5_wq_empty", 32'(wq0.size()), 32'd0);
        end

        sel = 1'b1;
        wait_clk(Q);

        // Pointer write, repeated START, 3-byte read (rdata = addr ^ 0xFF)
        ru_snap = ru1_cnt;
        rq1.push_back(8'h11);
        rq1.push_back(8'h12);
        rq1.push_back(8'h13);
        i2c_start();
        send_byte("t2_dev_w", 8'hE0, 1'b0, 1'b0);
        send_byte("t2_sub", 8'h10, 1'b0, 1'b0);
        i2c_start();
        send_byte("t2_dev_r", 8'hE1, 1'b0, 1'b0);
        recv_byte("t2_rd0", 8'hEF, 1'b0);
        recv_byte("t2_rd1", 8'hEE, 1'b0);
        recv_byte("t2_rd2", 8'hED, 1'b1);
        i2c_stop();
        check("t2_addr", 32'(bus1.addr), 32'h13);
        check("t2_rw", 32'(bus1.rw), 32'd1);
        check("t2_ru_pulses", 32'(ru1_cnt - ru_snap), 32'd3);
        check("t2_rq_empty", 32'(rq1.size()), 32'd0);

        // Foreign address 0x72: ignored completely
        oe_snap = oe1_cnt; wen_snap = wen1_cnt; ru_snap = ru1_cnt;
        i2c_start();
        send_byte("t3_nack", 8'hE4, 1'b1, 1'b0);
        send_byte("t3_ignored", 8'h00, 1'b1, 1'b0);
        i2c_stop();
        check("t3_oe_cycles", 32'(oe1_cnt - oe_snap), 32'd0);
        check("t3_wen", 32'(wen1_cnt - wen_snap), 32'd0);
        check("t3_ru", 32'(ru1_cnt - ru_snap), 32'd0);

        // Pointer wrap 0xFF -> 0x00
        wq1.push_back({8'hFF, 8'h11});
        wq1.push_back({8'h00, 8'h22});
        i2c_start();
        send_byte("t4_dev", 8'hE0, 1'b0, 1'b0);
        send_byte("t4_sub", 8'hFF, 1'b0, 1'b0);
        send_byte("t4_d0", 8'h11, 1'b0, 1'b0);
        send_byte("t4_d1", 8'h22, 1'b0, 1'b0);
        i2c_stop();
        check("t4_addr", 32'(bus1.addr), 32'h01);
        check("t4_wq_empty", 32'(wq1.size()), 32'd0);

        // Reset after the 4th address bit
        i2c_start();
        write_bit(1'b1, 1'b0);
        write_bit(1'b1, 1'b0);
        write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        check("t6_oe",    32'(bus1.sda_oe),     32'd0);
        check("t6_rw",    32'(bus1.rw),         32'd1);
        check("t6_addr",  32'(bus1.addr),       32'd0);
        check("t6_wen",   32'(bus1.wen),        32'd0);
        check("t6_wdata", 32'(bus1.wdata),      32'd0);
        check("t6_ru",    32'(bus1.rdata_used), 32'd0);
        check("t6_busy",  32'(bus1.busy),       32'd0);
        for (int i = 0; i < 4; i++) write_bit(1'b0, 1'b0);
        read_bit(a);
        check("t6_no_ack", 32'(a), 32'd1);
        i2c_stop();
        i2c_start();
        send_byte("t6_fresh_ack", 8'hE0, 1'b0, 1'b0);
        i2c_stop();
        check("t6_addr_end", 32'(bus1.addr), 32'd0);
        check("t6_busy_end", 32'(bus1.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
